vga_sync: RTL and testbench

Timing generator for the 640x480 @ 60 Hz text display path. Divides the system clock into a pixel tick, runs horizontal and vertical position counters, and produces `hsync`, `vsync`, `video_on` and the current `pixel_x`/`pixel_y`. It sits directly upstream of the character/font data generator and the VGA connector. That generator consumes `pixel_x`, `pixel_y` and `video_on`; the connector consumes `hsync` and `vsync`.

---
 rtl/vga_sync.sv | 114 +++++++++++
 tb/tb_vga_sync.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync
// Purpose  : 640x480@60 VGA timing generator: pixel-tick divider, h/v position
//            counters and registered hsync/vsync/video_on. Optional frame
//            start strobe and frame counter when VGA_FRAME_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic       frame_start,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW      = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          line_end;
    logic          frame_end;

    // p_tick is registered alongside tick_cnt, so it always equals (tick_cnt == TICK_MAX)
    always_comb begin
        tick_nxt  = (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
        line_end  = p_tick && (h_cnt == H_MAX);
        frame_end = line_end && (v_cnt == V_MAX);
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        if (p_tick) begin
            h_nxt = line_end ? '0 : h_cnt + 10'd1;
        end
        if (line_end) begin
            v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
        end
    end

    // Decoded outputs are computed from the next counter values so they line
    // up with pixel_x/pixel_y in the same cycle without a combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            p_tick   <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            tick_cnt <= tick_nxt;
            p_tick   <= (tick_nxt == TICK_MAX);
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            hsync    <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
            vsync    <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
            video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        end
    end

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

`ifdef VGA_FRAME_CNT_EN
    // frame_start marks the last tick of the frame; frame_cnt steps as (0,0) is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= (tick_nxt == TICK_MAX) && (h_nxt == H_MAX) && (v_nxt == V_MAX);
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync
// Purpose  : Directed self-checking bench for vga_sync: a full-size instance
//            for tick/line behaviour and a shrunken instance for frame timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       pt_a, hs_a, vs_a, vo_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, hs_b, vs_b, vo_b;
    logic [9:0] x_b, y_b;
`ifdef VGA_FRAME_CNT_EN
    logic       fs_a, fs_b;
    logic [7:0] fc_a, fc_b;
`endif

    vga_sync dut_a (
        .clk      (clk),
        .reset    (rst_a),
        .p_tick   (pt_a),
        .pixel_x  (x_a),
        .pixel_y  (y_a),
        .hsync    (hs_a),
        .vsync    (vs_a),
        .video_on (vo_a)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_start (fs_a),
        .frame_cnt   (fc_a)
`endif
    );

    // Shrunken timing: 16 ticks/line (hsync low x=10..12), 12 lines/frame
    // (vsync low y=8..9), 2 clks/tick -> 384 clks per frame.
    vga_sync #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .TICK_DIV  (2)
    ) dut_b (
        .clk      (clk),
        .reset    (rst_b),
        .p_tick   (pt_b),
        .pixel_x  (x_b),
        .pixel_y  (y_b),
        .hsync    (hs_b),
        .vsync    (vs_b),
        .video_on (vo_b)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_start (fs_b),
        .frame_cnt   (fc_b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    int         hi, dbl, viol, hs_clks, hs_min, hs_max, fall_x, fall_prev;
    int         wrap_from, wrap_to, done, n, vs_clks, vs_min, vs_max;
    int         arrivals, t1, t2, fs_cnt, fc_bad;
    logic       p_pt, p_hs, p_vs, p_vo;
    logic [9:0] p_x, p_y;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ptick", pt_a, 0);
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_video_on", vo_a, 1);

        // release and watch the first pixel tick
        rst_a = 1'b0;
        @(negedge clk); check("tick_c1", pt_a, 0);
        @(negedge clk); check("tick_c2", pt_a, 0);
        @(negedge clk); check("tick_first", pt_a, 1);
        check("x_before_tick", x_a, 0);
        @(negedge clk); check("tick_after", pt_a, 0);
        check("x_after_tick", x_a, 1);

        hi = 0; dbl = 0; p_pt = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (pt_a) hi++;
            if (pt_a && p_pt) dbl++;
            p_pt = pt_a;
        end
        check("tick_count_40clk", hi, 10);
        check("tick_width", dbl, 0);

        // scan the rest of line 0 into line 1
        viol = 0; hs_clks = 0; hs_min = 9999; hs_max = -1; fall_x = -1; fall_prev = -1;
        wrap_from = -1; wrap_to = -1; done = 0;
        p_pt = pt_a; p_x = x_a; p_y = y_a; p_hs = hs_a; p_vs = vs_a; p_vo = vo_a;
        for (int i = 0; i < 4000 && done == 0; i++) begin
            @(negedge clk);
            if (vo_a !== ((x_a < 10'd640) && (y_a < 10'd480))) viol++;
            if (x_a > 10'd799 || y_a > 10'd524) viol++;
            if (!p_pt && (x_a != p_x || y_a != p_y || hs_a != p_hs || vs_a != p_vs || vo_a != p_vo)) viol++;
            if (p_vo && !vo_a && fall_x < 0) begin
                fall_x = int'(x_a);
                fall_prev = int'(p_x);
            end
            if (!hs_a) begin
                hs_clks++;
                if (int'(x_a) < hs_min) hs_min = int'(x_a);
                if (int'(x_a) > hs_max) hs_max = int'(x_a);
            end
            if (y_a != p_y) begin
                wrap_from = int'(p_x);
                wrap_to = int'(x_a);
                done = 1;
            end
            p_pt = pt_a; p_x = x_a; p_y = y_a; p_hs = hs_a; p_vs = vs_a; p_vo = vo_a;
        end
        check("line_done", done, 1);
        check("vo_fall_x", fall_x, 640);
        check("vo_fall_prev_x", fall_prev, 639);
        check("hsync_low_clks", hs_clks, 384);
        check("hsync_first_x", hs_min, 656);
        check("hsync_last_x", hs_max, 751);
        check("hwrap_from", wrap_from, 799);
        check("hwrap_to", wrap_to, 0);
        check("y_after_wrap", y_a, 1);
        check("line_invariants", viol, 0);

        // one-clk reset mid-line
        done = 0;
        for (int i = 0; i < 2000 && done == 0; i++) begin
            @(negedge clk);
            if (x_a == 10'd300) done = 1;
        end
        check("reach_x300", done, 1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("midrst_x", x_a, 0);
        check("midrst_y", y_a, 0);
        check("midrst_hsync", hs_a, 1);
        check("midrst_vsync", vs_a, 1);
        check("midrst_ptick", pt_a, 0);
        repeat (3) @(negedge clk);
        check("resume_tick", pt_a, 1);
        @(negedge clk);
        check("resume_x", x_a, 1);

        // shrunken instance: two full frames with per-clk invariants
        rst_b = 1'b0;
        viol = 0; vs_clks = 0; vs_min = 9999; vs_max = -1; arrivals = 0; t1 = -1; t2 = -1;
        fs_cnt = 0; fc_bad = 0;
        @(negedge clk);
        p_pt = pt_b; p_x = x_b; p_y = y_b; p_hs = hs_b; p_vs = vs_b; p_vo = vo_b;
        for (int i = 1; i < 1000; i++) begin
            @(negedge clk);
            if (vo_b !== ((x_b < 10'd8) && (y_b < 10'd6))) viol++;
            if (hs_b !== !((x_b >= 10'd10) && (x_b <= 10'd12))) viol++;
            if (vs_b !== !((y_b >= 10'd8) && (y_b <= 10'd9))) viol++;
            if (x_b > 10'd15 || y_b > 10'd11) viol++;
            if (!p_pt && (x_b != p_x || y_b != p_y || hs_b != p_hs || vs_b != p_vs || vo_b != p_vo)) viol++;
            if (!vs_b) begin
                vs_clks++;
                if (int'(y_b) < vs_min) vs_min = int'(y_b);
                if (int'(y_b) > vs_max) vs_max = int'(y_b);
            end
`ifdef VGA_FRAME_CNT_EN
            if (fs_b) begin
                fs_cnt++;
                if (!(pt_b && x_b == 10'd15 && y_b == 10'd11)) fc_bad++;
            end
            if (pt_b && x_b == 10'd15 && y_b == 10'd11 && !fs_b) fc_bad++;
`endif
            if (p_x == 10'd15 && p_y == 10'd11 && x_b == 10'd0 && y_b == 10'd0) begin
                arrivals++;
                if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
`ifdef VGA_FRAME_CNT_EN
                if (int'(fc_b) != arrivals) fc_bad++;
`endif
            end
            p_pt = pt_b; p_x = x_b; p_y = y_b; p_hs = hs_b; p_vs = vs_b; p_vo = vo_b;
        end
        check("frame_arrivals", arrivals, 2);
        check("frame_period_clks", t2 - t1, 384);
        check("vsync_low_clks", vs_clks, 128);
        check("vsync_first_y", vs_min, 8);
        check("vsync_last_y", vs_max, 9);
        check("frame_invariants", viol, 0);
`ifdef VGA_FRAME_CNT_EN
        check("frame_start_pulses", fs_cnt, 2);
        check("frame_cnt_sequence", fc_bad, 0);
        check("frame_cnt_final", fc_b, 2);
`endif

        // mid-frame reset on the shrunken instance at (5,3)
        done = 0;
        for (int i = 0; i < 800 && done == 0; i++) begin
            @(negedge clk);
            if (x_b == 10'd5 && y_b == 10'd3) done = 1;
        end
        check("reach_5_3", done, 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("b_midrst_x", x_b, 0);
        check("b_midrst_y", y_b, 0);
        check("b_midrst_vo", vo_b, 1);
`ifdef VGA_FRAME_CNT_EN
        check("b_midrst_fc", fc_b, 0);
`endif
        @(negedge clk);
        check("b_resume_tick", pt_b, 1);
        @(negedge clk);
        check("b_resume_x", x_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
